// File: rtl/ctl_seq.sv
// ctl_seq: sequential control unit for the RISC core.
// Decodes the IR opcode into datapath controls and sequences multi-cycle work:
// memory waits, PUSHA store bursts, interrupt entry at instruction boundaries
// and ILLOP traps. PC/IR load only when pc_en is high.
module ctl_seq #(
    parameter int MULTI_W     = 5,
    parameter int PUSHA_COUNT = 7,
    parameter int IRQ_EN      = 1,
    parameter int ILLOP_EN    = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         op,
    input  logic               z,
    input  logic               irq,
    input  logic               mem_ready,
    output logic [5:0]         alufn,
    output logic [2:0]         pcsel,
    output logic [1:0]         wdsel,
    output logic               asel,
    output logic               bsel,
    output logic               moe,
    output logic               mwr,
    output logic               ra2sel,
    output logic               wasel,
    output logic               werf,
    output logic               pc_en,
    output logic [MULTI_W-1:0] beat,
    output logic               busy,
    output logic               irq_ack
);

    // Opcodes (Beta-style map; PUSHA occupies a free slot).
    localparam logic [5:0] OP_LD    = 6'h18;
    localparam logic [5:0] OP_ST    = 6'h19;
    localparam logic [5:0] OP_PUSHA = 6'h1A;
    localparam logic [5:0] OP_JMP   = 6'h1B;
    localparam logic [5:0] OP_BEQ   = 6'h1C;
    localparam logic [5:0] OP_BNE   = 6'h1D;
    localparam logic [5:0] OP_LDR   = 6'h1F;

    // ALU function codes.
    localparam logic [5:0] ALU_ADD   = 6'b000000;
    localparam logic [5:0] ALU_SUB   = 6'b000001;
    localparam logic [5:0] ALU_MUL   = 6'b000010;
    localparam logic [5:0] ALU_DIV   = 6'b000011;
    localparam logic [5:0] ALU_AND   = 6'b011000;
    localparam logic [5:0] ALU_OR    = 6'b011110;
    localparam logic [5:0] ALU_XOR   = 6'b010110;
    localparam logic [5:0] ALU_A     = 6'b011010;
    localparam logic [5:0] ALU_SHL   = 6'b100000;
    localparam logic [5:0] ALU_SHR   = 6'b100001;
    localparam logic [5:0] ALU_SRA   = 6'b100011;
    localparam logic [5:0] ALU_CMPEQ = 6'b110011;
    localparam logic [5:0] ALU_CMPLT = 6'b110101;
    localparam logic [5:0] ALU_CMPLE = 6'b110111;

    localparam logic [MULTI_W-1:0] BEAT_LAST = MULTI_W'(PUSHA_COUNT);

    typedef enum logic [1:0] {S_RST, S_EXEC, S_MEM_WAIT, S_MULTI} state_t;

    typedef struct packed {
        logic [5:0] alufn;
        logic [2:0] pcsel;
        logic [1:0] wdsel;
        logic       asel;
        logic       bsel;
        logic       moe;
        logic       mwr;
        logic       ra2sel;
        logic       wasel;
        logic       werf;
    } ctl_t;

    // {valid, function} for the low nibble of an OP/OPC opcode.
    function automatic logic [6:0] alu_lookup(input logic [3:0] f);
        case (f)
            4'h0:    return {1'b1, ALU_ADD};
            4'h1:    return {1'b1, ALU_SUB};
            4'h2:    return {1'b1, ALU_MUL};
            4'h3:    return {1'b1, ALU_DIV};
            4'h4:    return {1'b1, ALU_CMPEQ};
            4'h5:    return {1'b1, ALU_CMPLT};
            4'h6:    return {1'b1, ALU_CMPLE};
            4'h8:    return {1'b1, ALU_AND};
            4'h9:    return {1'b1, ALU_OR};
            4'hA:    return {1'b1, ALU_XOR};
            4'hC:    return {1'b1, ALU_SHL};
            4'hD:    return {1'b1, ALU_SHR};
            4'hE:    return {1'b1, ALU_SRA};
            default: return {1'b0, ALU_ADD};
        endcase
    endfunction

    state_t             state, state_nxt;
    logic [MULTI_W-1:0] beat_nxt;
    logic               irq_q, irq_pending, irq_rise;
    logic [6:0]         alu_dec;
    ctl_t               dec, ctl;
    logic               mapped, is_mem, is_pusha;
    logic               retire, ack;

    assign alu_dec  = alu_lookup(op[3:0]);
    assign irq_rise = irq & ~irq_q;

    // Combinational opcode decode into the op's native control word.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dec      = '0;
        mapped   = 1'b1;
        is_mem   = 1'b0;
        is_pusha = 1'b0;
        case (op)
            OP_LD: begin
                dec.alufn = ALU_ADD; dec.bsel = 1'b1; dec.wdsel = 2'd2;
                dec.moe   = 1'b1;    dec.werf = 1'b1; is_mem    = 1'b1;
            end
            OP_LDR: begin
                dec.alufn = ALU_A; dec.asel = 1'b1; dec.wdsel = 2'd2;
                dec.moe   = 1'b1;  dec.werf = 1'b1; is_mem    = 1'b1;
            end
            OP_ST: begin
                dec.alufn = ALU_ADD; dec.bsel = 1'b1; dec.ra2sel = 1'b1;
                dec.mwr   = 1'b1;    is_mem   = 1'b1;
            end
            OP_PUSHA: begin
                dec.alufn = ALU_ADD; dec.bsel = 1'b1; dec.ra2sel = 1'b1;
                dec.mwr   = 1'b1;    is_pusha = 1'b1;
            end
            OP_JMP: begin
                dec.pcsel = 3'd2; dec.werf = 1'b1;
            end
            OP_BEQ: begin
                dec.pcsel = {2'b00, z}; dec.werf = 1'b1;
            end
            OP_BNE: begin
                dec.pcsel = {2'b00, ~z}; dec.werf = 1'b1;
            end
            default: begin
                if (op[5] && alu_dec[6]) begin
                    dec.alufn = alu_dec[5:0];
                    dec.bsel  = op[4];
                    dec.wdsel = 2'd1;
                    dec.werf  = 1'b1;
                end else begin
                    mapped = 1'b0;
                end
            end
        endcase
    end

    // Next-state, beat sequencing and output control word.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        ctl       = '0;
        retire    = 1'b0;
        ack       = 1'b0;
        case (state)
            S_RST: state_nxt = S_EXEC;
            S_EXEC: begin
                if ((IRQ_EN != 0) && irq_pending) begin
                    ctl.pcsel = 3'd4; ctl.wasel = 1'b1; ctl.werf = 1'b1;
                    retire    = 1'b1; ack       = 1'b1;
                end else if (!mapped) begin
                    retire = 1'b1;
                    if (ILLOP_EN != 0) begin
                        ctl.pcsel = 3'd3; ctl.wasel = 1'b1; ctl.werf = 1'b1;
                    end
                end else if (is_mem) begin
                    ctl = dec;
                    if (mem_ready) begin
                        retire = 1'b1;
                    end else begin
                        ctl.werf  = 1'b0;
                        state_nxt = S_MEM_WAIT;
                    end
                end else if (is_pusha) begin
                    ctl = dec;
                    if (mem_ready && beat == BEAT_LAST) begin
                        retire   = 1'b1;
                        beat_nxt = '0;
                    end else begin
                        state_nxt = S_MULTI;
                        if (mem_ready) beat_nxt = beat + 1'b1;
                    end
                end else begin
                    ctl    = dec;
                    retire = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                ctl = dec;
                if (mem_ready) begin
                    retire    = 1'b1;
                    state_nxt = S_EXEC;
                end else begin
                    ctl.werf = 1'b0;
                end
            end
            S_MULTI: begin
                ctl = dec;
                if (mem_ready) begin
                    if (beat == BEAT_LAST) begin
                        retire    = 1'b1;
                        beat_nxt  = '0;
                        state_nxt = S_EXEC;
                    end else begin
                        beat_nxt = beat + 1'b1;
                    end
                end
            end
            default: state_nxt = S_RST;
        endcase
    end

    // State, beat counter and interrupt edge/pending registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_RST;
            beat        <= '0;
            irq_q       <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state       <= state_nxt;
            beat        <= beat_nxt;
            irq_q       <= irq;
            irq_pending <= (IRQ_EN != 0) && (irq_rise || (irq_pending && !ack));
        end
    end

    assign alufn   = ctl.alufn;
    assign pcsel   = ctl.pcsel;
    assign wdsel   = ctl.wdsel;
    assign asel    = ctl.asel;
    assign bsel    = ctl.bsel;
    assign moe     = ctl.moe;
    assign mwr     = ctl.mwr;
    assign ra2sel  = ctl.ra2sel;
    assign wasel   = ctl.wasel;
    assign werf    = ctl.werf;
    assign pc_en   = retire;
    assign irq_ack = ack;
    assign busy    = (state == S_MEM_WAIT) || (state == S_MULTI);

endmodule

// File: tb/tb_ctl_seq.sv
// tb_ctl_seq: directed checks of ctl_seq. A vector table covers single-cycle
// decode; hand sequences cover reset, memory waits, PUSHA bursts and IRQ entry.
// A second instance runs with ILLOP_EN=0 and IRQ_EN=0 on the same inputs.
module tb_ctl_seq;

    localparam logic [5:0] A_ADD   = 6'b000000;
    localparam logic [5:0] A_SUB   = 6'b000001;
    localparam logic [5:0] A_AND   = 6'b011000;
    localparam logic [5:0] A_A     = 6'b011010;
    localparam logic [5:0] A_SHR   = 6'b100001;
    localparam logic [5:0] A_CMPLT = 6'b110101;

    localparam logic [5:0] O_LD = 6'h18, O_ST = 6'h19, O_PUSHA = 6'h1A, O_JMP = 6'h1B;
    localparam logic [5:0] O_BEQ = 6'h1C, O_BNE = 6'h1D, O_LDR = 6'h1F, O_ADD = 6'h20;

    // Flag field order: asel bsel moe mwr ra2sel wasel werf pc_en busy irq_ack
    typedef struct packed {
        logic [5:0] alufn;
        logic [2:0] pcsel;
        logic [1:0] wdsel;
        logic [9:0] flags;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
        logic       mr;
        logic       unmapped;
        ctl_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic       z, irq, mem_ready;

    logic [5:0] alufn, alufn_n;
    logic [2:0] pcsel, pcsel_n;
    logic [1:0] wdsel, wdsel_n;
    logic       asel, bsel, moe, mwr, ra2sel, wasel, werf, pc_en, busy, irq_ack;
    logic       asel_n, bsel_n, moe_n, mwr_n, ra2sel_n, wasel_n, werf_n, pc_en_n, busy_n, irq_ack_n;
    logic [4:0] beat, beat_n;

    ctl_t got, got_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[16];

    always #5 clk = ~clk;

    ctl_seq dut (
        .clk(clk), .reset_n(reset_n), .op(op), .z(z), .irq(irq), .mem_ready(mem_ready),
        .alufn(alufn), .pcsel(pcsel), .wdsel(wdsel), .asel(asel), .bsel(bsel), .moe(moe),
        .mwr(mwr), .ra2sel(ra2sel), .wasel(wasel), .werf(werf), .pc_en(pc_en),
        .beat(beat), .busy(busy), .irq_ack(irq_ack)
    );

    ctl_seq #(.IRQ_EN(0), .ILLOP_EN(0)) dut_n (
        .clk(clk), .reset_n(reset_n), .op(op), .z(z), .irq(irq), .mem_ready(mem_ready),
        .alufn(alufn_n), .pcsel(pcsel_n), .wdsel(wdsel_n), .asel(asel_n), .bsel(bsel_n),
        .moe(moe_n), .mwr(mwr_n), .ra2sel(ra2sel_n), .wasel(wasel_n), .werf(werf_n),
        .pc_en(pc_en_n), .beat(beat_n), .busy(busy_n), .irq_ack(irq_ack_n)
    );

    assign got   = {alufn, pcsel, wdsel, asel, bsel, moe, mwr, ra2sel, wasel, werf,
                    pc_en, busy, irq_ack};
    assign got_n = {alufn_n, pcsel_n, wdsel_n, asel_n, bsel_n, moe_n, mwr_n, ra2sel_n,
                    wasel_n, werf_n, pc_en_n, busy_n, irq_ack_n};

    function automatic ctl_t mk(input logic [5:0] a, input logic [2:0] p,
                                input logic [1:0] w, input logic [9:0] f);
        return {a, p, w, f};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: apply inputs after the falling edge, settle, then caller checks.
    task automatic cyc(input logic [5:0] o, input logic zz, input logic mr, input logic ir);
        @(negedge clk);
        op = o; z = zz; mem_ready = mr; irq = ir;
        #2;
    endtask

    initial begin
        ctl_t e;
        logic mr_tab[10];
        int   beat_tab[10];

        vecs[0]  = '{6'h20, 1'b0, 1'b1, 1'b0, mk(A_ADD,   3'd0, 2'd1, 10'b0000001100)};
        vecs[1]  = '{6'h30, 1'b0, 1'b0, 1'b0, mk(A_ADD,   3'd0, 2'd1, 10'b0100001100)};
        vecs[2]  = '{6'h21, 1'b0, 1'b1, 1'b0, mk(A_SUB,   3'd0, 2'd1, 10'b0000001100)};
        vecs[3]  = '{6'h25, 1'b1, 1'b1, 1'b0, mk(A_CMPLT, 3'd0, 2'd1, 10'b0000001100)};
        vecs[4]  = '{6'h3D, 1'b0, 1'b1, 1'b0, mk(A_SHR,   3'd0, 2'd1, 10'b0100001100)};
        vecs[5]  = '{6'h28, 1'b0, 1'b0, 1'b0, mk(A_AND,   3'd0, 2'd1, 10'b0000001100)};
        vecs[6]  = '{O_LD,  1'b0, 1'b1, 1'b0, mk(A_ADD,   3'd0, 2'd2, 10'b0110001100)};
        vecs[7]  = '{O_LDR, 1'b0, 1'b1, 1'b0, mk(A_A,     3'd0, 2'd2, 10'b1010001100)};
        vecs[8]  = '{O_ST,  1'b0, 1'b1, 1'b0, mk(A_ADD,   3'd0, 2'd0, 10'b0101100100)};
        vecs[9]  = '{O_JMP, 1'b0, 1'b1, 1'b0, mk(A_ADD,   3'd2, 2'd0, 10'b0000001100)};
        vecs[10] = '{O_BEQ, 1'b1, 1'b1, 1'b0, mk(A_ADD,   3'd1, 2'd0, 10'b0000001100)};
        vecs[11] = '{O_BEQ, 1'b0, 1'b1, 1'b0, mk(A_ADD,   3'd0, 2'd0, 10'b0000001100)};
        vecs[12] = '{O_BNE, 1'b0, 1'b1, 1'b0, mk(A_ADD,   3'd1, 2'd0, 10'b0000001100)};
        vecs[13] = '{O_BNE, 1'b1, 1'b1, 1'b0, mk(A_ADD,   3'd0, 2'd0, 10'b0000001100)};
        vecs[14] = '{6'h3F, 1'b0, 1'b1, 1'b1, mk(A_ADD,   3'd3, 2'd0, 10'b0000011100)};
        vecs[15] = '{6'h05, 1'b1, 1'b0, 1'b1, mk(A_ADD,   3'd3, 2'd0, 10'b0000011100)};

        // Reset state, then release: one dead cycle before the first retire.
        reset_n = 1'b0; op = O_PUSHA; z = 1'b0; mem_ready = 1'b1; irq = 1'b0;
        #1;
        check("reset_outputs", 32'(got), 32'(0));
        check("reset_beat", 32'(beat), 32'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1; op = O_ADD;
        #2;
        check("dead_cycle", 32'(got), 32'(0));
        cyc(O_ADD, 1'b0, 1'b1, 1'b0);
        check("first_exec", 32'(got), 32'(vecs[0].exp));

        // Single-cycle decode table.
        for (int i = 0; i < 16; i++) begin
            cyc(vecs[i].op, vecs[i].z, vecs[i].mr, 1'b0);
            check($sformatf("vec%0d", i), 32'(got), 32'(vecs[i].exp));
            e = vecs[i].unmapped ? mk(A_ADD, 3'd0, 2'd0, 10'b0000000100) : vecs[i].exp;
            check($sformatf("vec%0d_noill", i), 32'(got_n), 32'(e));
        end

        // LD with three wait cycles.
        cyc(O_LD, 1'b0, 1'b0, 1'b0);
        check("ld_c1", 32'(got), 32'(mk(A_ADD, 3'd0, 2'd2, 10'b0110000000)));
        for (int i = 0; i < 2; i++) begin
            cyc(O_LD, 1'b0, 1'b0, 1'b0);
            check($sformatf("ld_wait%0d", i), 32'(got), 32'(mk(A_ADD, 3'd0, 2'd2, 10'b0110000010)));
        end
        cyc(O_LD, 1'b0, 1'b1, 1'b0);
        check("ld_c4", 32'(got), 32'(mk(A_ADD, 3'd0, 2'd2, 10'b0110001110)));
        cyc(O_ADD, 1'b0, 1'b1, 1'b0);
        check("ld_after", 32'(got), 32'(vecs[0].exp));

        // ST with one wait cycle: mwr stays up until completion.
        cyc(O_ST, 1'b0, 1'b0, 1'b0);
        check("st_c1", 32'(got), 32'(mk(A_ADD, 3'd0, 2'd0, 10'b0101100000)));
        cyc(O_ST, 1'b0, 1'b1, 1'b0);
        check("st_c2", 32'(got), 32'(mk(A_ADD, 3'd0, 2'd0, 10'b0101100110)));

        // PUSHA, memory always ready: eight beats.
        for (int i = 0; i < 8; i++) begin
            cyc(O_PUSHA, 1'b0, 1'b1, 1'b0);
            e = mk(A_ADD, 3'd0, 2'd0, {8'b01011000, 1'b0, 1'b0});
            e.flags[2] = (i == 7);
            e.flags[1] = (i > 0);
            check($sformatf("push_ctl%0d", i), 32'(got), 32'(e));
            check($sformatf("push_beat%0d", i), 32'(beat), 32'(i));
        end
        cyc(O_ADD, 1'b0, 1'b1, 1'b0);
        check("push_after", 32'(got), 32'(vecs[0].exp));

        // PUSHA stalled two cycles at beat 4: ten cycles in total.
        mr_tab   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        beat_tab = '{0, 1, 2, 3, 4, 4, 4, 5, 6, 7};
        for (int i = 0; i < 10; i++) begin
            cyc(O_PUSHA, 1'b0, mr_tab[i], 1'b0);
            check($sformatf("stall_beat%0d", i), 32'(beat), 32'(beat_tab[i]));
            check($sformatf("stall_pc_en%0d", i), 32'(pc_en), 32'(i == 9));
            check($sformatf("stall_mwr%0d", i), 32'(mwr), 32'(1));
        end

        // IRQ pulse mid-burst: no preemption, taken after retire, re-armed in ack cycle.
        for (int i = 0; i < 8; i++) begin
            cyc(O_PUSHA, 1'b0, 1'b1, i == 2);
            check($sformatf("irqpush_ack%0d", i), 32'(irq_ack), 32'(0));
            check($sformatf("irqpush_pc_en%0d", i), 32'(pc_en), 32'(i == 7));
        end
        cyc(O_ADD, 1'b0, 1'b1, 1'b1);
        check("irq_take1", 32'(got), 32'(mk(A_ADD, 3'd4, 2'd0, 10'b0000011101)));
        check("irq_disabled", 32'(got_n), 32'(vecs[0].exp));
        cyc(O_ADD, 1'b0, 1'b1, 1'b0);
        check("irq_take2", 32'(got), 32'(mk(A_ADD, 3'd4, 2'd0, 10'b0000011101)));
        cyc(O_ADD, 1'b0, 1'b1, 1'b0);
        check("irq_done", 32'(got), 32'(vecs[0].exp));

        // Reset during PUSHA beat 3: everything drops at once, burst abandoned.
        for (int i = 0; i < 4; i++) cyc(O_PUSHA, 1'b0, 1'b1, 1'b0);
        check("rst_pre_beat", 32'(beat), 32'(3));
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_outputs", 32'(got), 32'(0));
        check("rst_mid_beat", 32'(beat), 32'(0));
        @(negedge clk);
        #2;
        check("rst_hold", 32'(got), 32'(0));
        @(negedge clk);
        reset_n = 1'b1; op = O_ADD;
        #2;
        check("rst_dead_cycle", 32'(got), 32'(0));
        check("rst_dead_beat", 32'(beat), 32'(0));
        cyc(O_ADD, 1'b0, 1'b1, 1'b0);
        check("rst_resume", 32'(got), 32'(vecs[0].exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
